fifo_byte_packer: RTL and testbench



---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_packer_outreg.sv | 43 ++++
 rtl/fifo_byte_packer.sv | 104 ++++++++++
 tb/tb_fifo_byte_packer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO byte packer.
package fifo_pkg;

    localparam int unsigned PKG_IN_WIDTH = 8;
    localparam int unsigned PKG_RATIO    = 4;
    localparam int unsigned CNT_W        = $clog2(PKG_RATIO);
    localparam int unsigned MASK_MAX     = 64;

    // Contiguous lane-keep mask with the low 'fill' lanes set, clipped to 'ratio' lanes.
    function automatic logic [MASK_MAX-1:0] keep_mask(input int unsigned fill,
                                                      input int unsigned ratio);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_MAX; i++) begin
            m[i] = (i < fill) && (i < ratio);
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_packer_outreg.sv
// Single-entry valid/ready output register holding one packed word and its lane-keep mask.
module fifo_packer_outreg #(
    parameter int unsigned DW    = 32,
    parameter int unsigned RATIO = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [DW-1:0]    i_data,
    input  logic [RATIO-1:0] i_keep,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [DW-1:0]    o_data,
    output logic [RATIO-1:0] o_keep,
    output logic             o_slot_free_c
);

    logic             r_valid;
    logic [DW-1:0]    r_data;
    logic [RATIO-1:0] r_keep;

    // Slot can take a new word if empty or its current word drains this cycle.
    assign o_slot_free_c = !r_valid || i_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;

endmodule

// File: rtl/fifo_byte_packer.sv
// Drains a lookahead FIFO and packs RATIO narrow entries per wide output word, with flush support.
module fifo_byte_packer
    import fifo_pkg::*;
#(
    parameter int unsigned IN_WIDTH = PKG_IN_WIDTH,
    parameter int unsigned RATIO    = PKG_RATIO
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fifo_empty,
    input  logic [IN_WIDTH-1:0]       fifo_dout,
    output logic                      fifo_rd,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]          out_keep
);

    localparam int unsigned DW = IN_WIDTH * RATIO;
    localparam int unsigned CW = (RATIO == PKG_RATIO) ? CNT_W : $clog2(RATIO);
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    logic [CW-1:0]    r_cnt;
    logic [DW-1:0]    r_acc;
    logic             r_flush_pending;

    logic             w_slot_free;
    logic             w_last;
    logic             w_pop;
    logic             w_full;
    logic             w_emit_part;
    logic             w_load;
    logic             w_start_pend;
    logic [DW-1:0]    w_acc_next;
    logic [DW-1:0]    w_load_data;
    logic [RATIO-1:0] w_load_keep;

    // The last lane may only be popped when the finished word has somewhere to go.
    assign w_last       = (r_cnt == LAST_LANE);
    assign w_pop        = rst_n && !fifo_empty && !r_flush_pending && !(w_last && !w_slot_free);
    assign fifo_rd      = w_pop;
    assign w_full       = w_pop && w_last;
    assign w_emit_part  = r_flush_pending && w_slot_free;
    assign w_load       = w_full || w_emit_part;
    assign w_start_pend = flush && !r_flush_pending && !w_full && (w_pop || (r_cnt != '0));

    // Accumulator with the current pop written into its lane.
    always_comb begin
        w_acc_next = r_acc;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (w_pop && (r_cnt == CW'(i))) begin
                w_acc_next[i*IN_WIDTH +: IN_WIDTH] = fifo_dout;
            end
        end
    end

    always_comb begin
        w_load_data = r_acc;
        w_load_keep = RATIO'(keep_mask(32'(r_cnt), RATIO));
        if (w_full) begin
            w_load_data = w_acc_next;
            w_load_keep = '1;
        end
    end

    // Lane counter, accumulator and flush bookkeeping; every emission restarts at lane 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt           <= '0;
            r_acc           <= '0;
            r_flush_pending <= 1'b0;
        end else if (w_load) begin
            r_cnt           <= '0;
            r_acc           <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            r_acc <= w_acc_next;
            if (w_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_start_pend) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

    fifo_packer_outreg #(
        .DW    (DW),
        .RATIO (RATIO)
    ) u_outreg (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_load),
        .i_data        (w_load_data),
        .i_keep        (w_load_keep),
        .i_ready       (out_ready),
        .o_valid       (out_valid),
        .o_data        (out_data),
        .o_keep        (out_keep),
        .o_slot_free_c (w_slot_free)
    );

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed and randomized bench for fifo_byte_packer with a lookahead FIFO model.
module tb_fifo_byte_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_rd;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_keep;

    logic [7:0]  fq[$];
    logic [31:0] got_d[$];
    logic [3:0]  got_k[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          rd_empty_cnt = 0;
    logic        last_rd = 1'b0;
    logic        saw_valid = 1'b0;

    fifo_byte_packer #(
        .IN_WIDTH (8),
        .RATIO    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: present FIFO head, sample before the edge, pop after it.
    task automatic cycle(input logic fl);
        logic rd;
        logic acc;
        flush      = fl;
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : 8'h00;
        #1;
        rd      = fifo_rd;
        acc     = out_valid && out_ready;
        last_rd = rd;
        if (rd && fifo_empty) rd_empty_cnt++;
        if (out_valid === 1'b1) saw_valid = 1'b1;
        if (acc === 1'b1) begin
            got_d.push_back(out_data);
            got_k.push_back(out_keep);
        end
        @(posedge clk);
        if (rd === 1'b1 && fq.size() != 0) void'(fq.pop_front());
        #1;
        flush      = 1'b0;
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic clear_got();
        got_d.delete();
        got_k.delete();
    endtask

    task automatic test_reset();
        fq = '{8'h12, 8'h34};
        out_ready = 1'b1;
        rst_n = 1'b0;
        cycle(1'b0);
        cycle(1'b0);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 00000000", out_data); end
        n_cmp++;
        if (out_keep !== 4'h0) begin n_err++; $display("FAIL reset_keep: got %b want 0000", out_keep); end
        n_cmp++;
        if (last_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %b want 0", last_rd); end
        n_cmp++;
        if (fq.size() != 2) begin n_err++; $display("FAIL reset_nopop: fifo level %0d want 2", fq.size()); end
        rst_n = 1'b1;
        fq.delete();
        cycle(1'b0);
        clear_got();
    endtask

    task automatic test_full_words();
        int rd_hi = 0;
        clear_got();
        out_ready = 1'b1;
        fq = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2, 8'hA0, 8'h7A};
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0);
            if (last_rd === 1'b1) rd_hi++;
            if (i == 3) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== 32'hC409F65A) begin
                    n_err++;
                    $display("FAIL full_latency: valid=%b data=%h want 1 C409F65A", out_valid, out_data);
                end
            end
        end
        repeat (4) cycle(1'b0);
        n_cmp++;
        if (rd_hi != 8) begin n_err++; $display("FAIL full_throughput: rd high %0d cycles want 8", rd_hi); end
        n_cmp++;
        if (got_d.size() != 2) begin
            n_err++; $display("FAIL full_count: got %0d words want 2", got_d.size());
        end else begin
            n_cmp++;
            if (got_d[0] !== 32'hC409F65A || got_k[0] !== 4'hF) begin
                n_err++; $display("FAIL full_word0: got %h/%b want C409F65A/1111", got_d[0], got_k[0]);
            end
            n_cmp++;
            if (got_d[1] !== 32'h7AA0E281 || got_k[1] !== 4'hF) begin
                n_err++; $display("FAIL full_word1: got %h/%b want 7AA0E281/1111", got_d[1], got_k[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_got();
        out_ready = 1'b0;
        fq = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2, 8'hA0, 8'h7A};
        repeat (10) cycle(1'b0);
        n_cmp++;
        if (last_rd !== 1'b0) begin n_err++; $display("FAIL bp_stall_rd: got %b want 0", last_rd); end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'hC409F65A) begin
            n_err++; $display("FAIL bp_hold: valid=%b data=%h want 1 C409F65A", out_valid, out_data);
        end
        n_cmp++;
        if (fq.size() != 1) begin n_err++; $display("FAIL bp_level: fifo level %0d want 1", fq.size()); end
        out_ready = 1'b1;
        repeat (4) cycle(1'b0);
        n_cmp++;
        if (got_d.size() != 2) begin
            n_err++; $display("FAIL bp_count: got %0d words want 2", got_d.size());
        end else begin
            n_cmp++;
            if (got_d[0] !== 32'hC409F65A || got_d[1] !== 32'h7AA0E281) begin
                n_err++; $display("FAIL bp_order: got %h %h want C409F65A 7AA0E281", got_d[0], got_d[1]);
            end
        end
    endtask

    task automatic test_flush_partial();
        clear_got();
        out_ready = 1'b1;
        fq = '{8'h11, 8'h22, 8'h33};
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
        cycle(1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h00332211 || out_keep !== 4'b0111) begin
            n_err++;
            $display("FAIL flush_partial: valid=%b data=%h keep=%b want 1 00332211 0111", out_valid, out_data, out_keep);
        end
        fq = '{8'h44, 8'h55, 8'h66, 8'h77};
        repeat (7) cycle(1'b0);
        n_cmp++;
        if (got_d.size() != 2) begin
            n_err++; $display("FAIL flush_next_count: got %0d words want 2", got_d.size());
        end else begin
            n_cmp++;
            if (got_d[1] !== 32'h77665544 || got_k[1] !== 4'hF) begin
                n_err++; $display("FAIL flush_next_lane0: got %h/%b want 77665544/1111", got_d[1], got_k[1]);
            end
        end
    endtask

    task automatic test_flush_full();
        clear_got();
        out_ready = 1'b1;
        fq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        repeat (3) cycle(1'b0);
        cycle(1'b1);
        repeat (5) cycle(1'b0);
        n_cmp++;
        if (got_d.size() != 1) begin
            n_err++; $display("FAIL flush_full_count: got %0d words want 1", got_d.size());
        end else begin
            n_cmp++;
            if (got_d[0] !== 32'hDDCCBBAA || got_k[0] !== 4'hF) begin
                n_err++; $display("FAIL flush_full_word: got %h/%b want DDCCBBAA/1111", got_d[0], got_k[0]);
            end
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_full_idle: valid=%b want 0", out_valid); end
    endtask

    task automatic test_flush_empty();
        clear_got();
        out_ready = 1'b1;
        saw_valid = 1'b0;
        cycle(1'b1);
        repeat (3) cycle(1'b0);
        n_cmp++;
        if (saw_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty_noop: saw valid=%b want 0", saw_valid); end
        fq = '{8'h01, 8'h02, 8'h03, 8'h04};
        repeat (6) cycle(1'b0);
        n_cmp++;
        if (got_d.size() != 1 || got_d[0] !== 32'h04030201) begin
            n_err++;
            $display("FAIL flush_empty_after: got %0d words first=%h want 1 04030201",
                     got_d.size(), (got_d.size() != 0) ? got_d[0] : 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        clear_got();
        out_ready = 1'b1;
        fq = '{8'hE1, 8'hE2};
        cycle(1'b0);
        cycle(1'b0);
        fq = '{8'h5A, 8'hF6, 8'h09, 8'hC4};
        rst_n = 1'b0;
        cycle(1'b0);
        n_cmp++;
        if (last_rd !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_idle: rd=%b valid=%b want 0 0", last_rd, out_valid);
        end
        rst_n = 1'b1;
        repeat (6) cycle(1'b0);
        n_cmp++;
        if (got_d.size() != 1 || got_d[0] !== 32'hC409F65A || got_k[0] !== 4'hF) begin
            n_err++;
            $display("FAIL rstmid_word: got %0d words first=%h want 1 C409F65A",
                     got_d.size(), (got_d.size() != 0) ? got_d[0] : 32'h0);
        end
    endtask

    task automatic test_random();
        logic [7:0]  src[$];
        logic [31:0] exp_d[$];
        logic [31:0] w;
        int          printed = 0;
        int          budget = 0;
        int          n_words;
        clear_got();
        w = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(255));
            src.push_back(b);
            w = w | (32'(b) << (8 * (i % 4)));
            if ((i % 4) == 3) begin
                exp_d.push_back(w);
                w = 32'h0;
            end
        end
        while ((got_d.size() < 256) && (budget < 8000)) begin
            if (src.size() != 0 && $urandom_range(3) != 0) fq.push_back(src.pop_front());
            out_ready = ($urandom_range(1) == 1);
            cycle(1'b0);
            budget++;
        end
        out_ready = 1'b1;
        n_cmp++;
        if (got_d.size() != 256) begin
            n_err++; $display("FAIL rand_count: got %0d words want 256 after %0d cycles", got_d.size(), budget);
        end
        n_words = (got_d.size() < 256) ? got_d.size() : 256;
        for (int i = 0; i < n_words; i++) begin
            n_cmp++;
            if (got_d[i] !== exp_d[i] || got_k[i] !== 4'hF) begin
                n_err++;
                if (printed < 8) begin
                    printed++;
                    $display("FAIL rand_word[%0d]: got %h/%b want %h/1111", i, got_d[i], got_k[i], exp_d[i]);
                end
            end
        end
        n_cmp++;
        if (rd_empty_cnt != 0) begin n_err++; $display("FAIL rd_while_empty: %0d cycles want 0", rd_empty_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_backpressure();
        test_flush_partial();
        test_flush_full();
        test_flush_empty();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
